// File: rtl/omi_lane_src.sv
// omi_lane_src: serialises 66b blocks into PHY_BITS lane beats, with header phase, slip and gearbox pauses
//   clk, rst          : clock, synchronous active-high reset
//   blk_valid/_header/_data : 66b block offered by the source
//   blk_ready         : block taken this cycle; asserted regardless of blk_valid, and an idle block is loaded if none is offered
//   ln_rx_valid/_header/_data : registered beat stream toward the host lane receiver
//   ln_rx_slip        : rising edge advances the header-boundary phase by one beat
//   phase, slip_cnt   : current header phase, saturating count of honoured slips
//   OMI_LANE_PRBS_EN  : when defined, idle payload comes from a PRBS23 LFSR instead of zeros
module omi_lane_src #(
    parameter int PHY_BITS   = 8,
    parameter int GAP_PERIOD = 32,
    parameter int INIT_PHASE = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            blk_valid,
    input  logic [1:0]                      blk_header,
    input  logic [63:0]                     blk_data,
    output logic                            blk_ready,
    output logic                            ln_rx_valid,
    output logic [1:0]                      ln_rx_header,
    output logic [PHY_BITS-1:0]             ln_rx_data,
    input  logic                            ln_rx_slip,
    output logic [$clog2(64/PHY_BITS)-1:0]  phase,
    output logic [7:0]                      slip_cnt
);
    localparam int BEATS = 64 / PHY_BITS;
    localparam int PW = $clog2(BEATS);
    localparam logic [PW-1:0] LAST = PW'(BEATS - 1);
    localparam logic [PW-1:0] PH0 = PW'(INIT_PHASE);

    logic [63:0] blk_q, blk_d, in_data, idle_data;
    logic [1:0] bhdr_q, bhdr_d, hdr_q, hdr_d, in_hdr;
    logic [PW-1:0] cur_q, cur_d, phase_q, phase_d;
    logic [31:0] bcnt_q, bcnt_d;
    logic [PHY_BITS-1:0] data_q, data_d;
    logic [7:0] scnt_q, scnt_d;
    logic valid_q, valid_d, pause_q, pause_d, started_q, started_d, slip_q, slip_d;
    logic last, load, slip_edge;

`ifdef OMI_LANE_PRBS_EN
    logic [22:0] lfsr_q, lfsr_d, lfsr_nx;

    // Unroll 64 LFSR steps; payload bit k is the k-th generated bit.
    always_comb begin
        lfsr_nx = lfsr_q;
        idle_data = '0;
        for (int k = 0; k < 64; k++) begin
            idle_data[k] = lfsr_nx[22] ^ lfsr_nx[17];
            lfsr_nx = {lfsr_nx[21:0], idle_data[k]};
        end
        lfsr_d = (load && !blk_valid) ? lfsr_nx : lfsr_q;
    end

    always_ff @(posedge clk) lfsr_q <= rst ? '1 : lfsr_d;
`else
    assign idle_data = '0;
`endif

    always_comb begin
        in_data = blk_valid ? blk_data : idle_data;
        in_hdr = blk_valid ? blk_header : 2'b10;
        last = valid_q && cur_q == LAST;
        // A completed block that closes a gap period turns the next cycle into a pause, which then does the load.
        pause_d = last && GAP_PERIOD != 0 && bcnt_q + 32'd1 == 32'(GAP_PERIOD);
        load = !started_q || pause_q || (last && !pause_d);
        blk_ready = load && !rst;
        slip_edge = ln_rx_slip && !slip_q;
        slip_d = ln_rx_slip;
        phase_d = slip_edge ? phase_q + PW'(1) : phase_q;
        scnt_d = (slip_edge && scnt_q != 8'hff) ? scnt_q + 8'd1 : scnt_q;
        started_d = 1'b1;
        bcnt_d = last ? (pause_d ? '0 : bcnt_q + 32'd1) : bcnt_q;
        blk_d = load ? in_data : blk_q;
        bhdr_d = load ? in_hdr : bhdr_q;
        cur_d = load ? '0 : (valid_q && !last) ? cur_q + PW'(1) : cur_q;
        valid_d = load || (valid_q && !last);
        // Beat 0 bypasses the block register so a loaded block starts the very next cycle.
        data_d = load ? in_data[PHY_BITS-1:0] :
                 valid_d ? blk_q[int'(cur_d)*PHY_BITS +: PHY_BITS] : data_q;
        hdr_d = (!valid_d || cur_d != phase_q) ? hdr_q : (load ? in_hdr : bhdr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q     <= '0;
            bhdr_q    <= '0;
            hdr_q     <= '0;
            cur_q     <= '0;
            phase_q   <= PH0;
            bcnt_q    <= '0;
            data_q    <= '0;
            scnt_q    <= '0;
            valid_q   <= 1'b0;
            pause_q   <= 1'b0;
            started_q <= 1'b0;
            slip_q    <= 1'b0;
        end else begin
            blk_q     <= blk_d;
            bhdr_q    <= bhdr_d;
            hdr_q     <= hdr_d;
            cur_q     <= cur_d;
            phase_q   <= phase_d;
            bcnt_q    <= bcnt_d;
            data_q    <= data_d;
            scnt_q    <= scnt_d;
            valid_q   <= valid_d;
            pause_q   <= pause_d;
            started_q <= started_d;
            slip_q    <= slip_d;
        end
    end

    assign ln_rx_valid = valid_q;
    assign ln_rx_header = hdr_q;
    assign ln_rx_data = data_q;
    assign phase = phase_q;
    assign slip_cnt = scnt_q;
endmodule

// File: doc/omi_lane_src.md
OMI_LANE_SRC -- requirements
Module: omi_lane_src

Interface
REQ-001 Parameter PHY_BITS, default 8: lane beat width; legal values 8, 16, 32; BEATS = 64/PHY_BITS.
REQ-002 Parameter GAP_PERIOD, default 32: blocks between gearbox pause cycles; 0 disables pauses.
REQ-003 Parameter INIT_PHASE, default 3: header-boundary phase loaded at reset; range 0..BEATS-1.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 blk_valid  input  1  66b block offered by the source.
REQ-007 blk_header  input  2  sync header of the offered block.
REQ-008 blk_data  input  64  payload of the offered block.
REQ-009 blk_ready  output  1  block accepted this cycle when blk_valid is high.
REQ-010 ln_rx_valid  output  1  beat valid toward the host lane receiver.
REQ-011 ln_rx_header  output  2  header presented with each beat.
REQ-012 ln_rx_data  output  PHY_BITS  lane beat data.
REQ-013 ln_rx_slip  input  1  slip request from the host receiver.
REQ-014 phase  output  $clog2(BEATS)  current header-boundary phase.
REQ-015 slip_cnt  output  8  count of slips honoured, saturating.

Function
REQ-016 Beat i of a block (i = 0..BEATS-1) SHALL be blk_data[PHY_BITS*i +: PHY_BITS], LSB beat first.
REQ-017 Block register load: in the cycle after reset release, and in the cycle ln_rx_data shows beat BEATS-1 with the next cycle not a pause; if the next cycle is a pause, the load moves to the pause cycle.
REQ-018 blk_ready SHALL equal the load condition, independent of blk_valid.
REQ-019 Load with blk_valid low SHALL load an idle block: header 2'b10, payload per REQ-031.
REQ-020 Latency: a block loaded in cycle T drives beat 0 in T+1 and beat i in T+1+i, plus one cycle per intervening pause.
REQ-021 ln_rx_data, ln_rx_header and ln_rx_valid SHALL be registered outputs.
REQ-022 Pause: after every GAP_PERIOD completed blocks, one cycle with ln_rx_valid=0; data and header hold; beat counter holds.
REQ-023 ln_rx_header SHALL update only on a valid beat whose beat index equals phase, taking the header of the block in that beat, and hold otherwise.
REQ-024 Slip: a rising edge of ln_rx_slip SHALL set phase to (phase+1) mod BEATS one cycle later; slip held high counts once.
REQ-025 A slip edge during a pause cycle SHALL be honoured identically.
REQ-026 slip_cnt SHALL increment per honoured slip and saturate at 255.
REQ-027 Slip SHALL NOT change data order, block acceptance or pause timing.

Reset
REQ-028 During and after rst: ln_rx_valid=0, ln_rx_data=0, ln_rx_header=0, blk_ready=0, phase=INIT_PHASE, slip_cnt=0, beat counter=0, block counter=0, slip edge register=0.
REQ-029 rst asserted mid-block SHALL discard the in-flight block; it is not re-emitted.
REQ-030 First load after reset release SHALL occur in the first cycle with rst low.

Configuration
REQ-031 Macro OMI_LANE_PRBS_EN defined: idle payload is 64 successive bits of a PRBS23 (x^23+x^18+1) LFSR, seed all-ones at reset, advanced 64 bits per idle block only; undefined: idle payload all-zero and no LFSR logic.

Verification
REQ-032 PHY_BITS=8, GAP_PERIOD=0: block {hdr 01, data 0x0706050403020100} loaded at T -> ln_rx_data 0x00..0x07 in T+1..T+8, ln_rx_valid=1 throughout.
REQ-033 PHY_BITS=8, INIT_PHASE=3, back-to-back blocks hdr 01 then 10 -> ln_rx_header switches 01->10 on beat 3 of the second block, not beat 0.
REQ-034 INIT_PHASE=3, five single-cycle slip pulses -> phase 3->4->5->6->7->0, slip_cnt=5; header then switches on beat 0.
REQ-035 GAP_PERIOD=2, continuous valid blocks -> one ln_rx_valid=0 cycle after every 2nd block; blk_ready asserts in the pause cycle; no data beat lost or duplicated.
REQ-036 blk_valid held low -> header 2'b10, payload 0 (macro undefined) or PRBS23 sequence from all-ones seed (macro defined).
REQ-037 rst pulsed at beat 4 of a block -> next cycle all outputs at reset values, the following load accepts a new block, and the old beats 5..7 never appear.
